// File: rtl/linebuf_pkg.sv
// Shared constants, writer state encoding and lane parity helper for the
// ping-pong line buffer responder.
package linebuf_pkg;

  // Read request to read data, in clock cycles.
  localparam int RD_LAT = 2;

  // Widest lane the parity helper accepts; narrower lanes are zero-extended.
  localparam int LANE_MAX = 64;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_ROW  = 1'b1
  } wr_state_e;

  // Even-parity bit for one lane: makes the total count of ones even.
  function automatic logic lane_parity(input logic [LANE_MAX-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old word.
module sdp_ram #(
  parameter int WIDTH = 54,
  parameter int DEPTH = 2048
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage and read register; both non-blocking so reads see the pre-write word.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/linebuf_pingpong_resp.sv
// Ping-pong line buffer responder: writer fills one bank while the reader
// drains the other; fixed two-cycle read latency, hazard and overflow flags.
// Optional build macro LINEBUF_PARITY_EN adds one even-parity bit per lane.
//
// Handshake: i_wrvld / i_rdreq are single-cycle strobes with no back-pressure;
// every accepted i_rdreq yields exactly one o_rdvld cycle RD_LAT cycles later.
module linebuf_pingpong_resp
  import linebuf_pkg::*;
#(
  parameter int WIDTH_D = 27,
  parameter int THREAD  = 2,
  parameter int WIDTH_A = 10,
  parameter int DEPTH   = 1024
) (
  input  logic                      i_sclk,
  input  logic                      i_rst,
  input  logic                      i_vsync,
  input  logic                      i_wrvld,
  input  logic [WIDTH_D*THREAD-1:0] i_wrdat,
  input  logic [WIDTH_A-1:0]        i_wrcnt,
  input  logic                      i_rdreq,
  input  logic [WIDTH_A-1:0]        i_rdcnt,
  output logic [WIDTH_D*THREAD-1:0] o_rddat,
  output logic                      o_rdvld,
  output logic                      o_wrbank,
  output logic                      o_rdbank,
  output logic                      o_rdhaz,
  output logic                      o_wrovf,
  output logic                      o_parerr
);

  localparam int W  = WIDTH_D * THREAD;
  localparam int LA = $clog2(DEPTH);
`ifdef LINEBUF_PARITY_EN
  localparam int RAM_W = W + THREAD;
`else
  localparam int RAM_W = W;
`endif
  localparam logic [WIDTH_A:0] DEPTH_X = (WIDTH_A+1)'(DEPTH);

  // Writer state
  wr_state_e          wr_state_q, wr_state_d;
  logic               wr_bank_q, wr_bank_d;
  logic [WIDTH_A-1:0] wr_hi_q, wr_hi_d;
  logic               last_nz_q, last_nz_d;
  logic               wrovf_q, wrovf_d;
  // Reader state
  logic               rd_active_q, rd_active_d;
  logic               rd_bank_q, rd_bank_d;
  logic               rdhaz_q, rdhaz_d;
  // Read pipeline
  logic [RD_LAT-1:0]  vld_pipe_q;
  logic               s1_oob_q;
  logic [W-1:0]       rddat_q, rddat_d;
  logic               parerr_q, parerr_d;

  logic               wr_ovf, wr_acc, wr_toggle, wr_bank_eff;
  logic               rd_go, rd_latch, rd_bank_eff, rd_oob, rd_haz;
  logic [RAM_W-1:0]   ram_wdata, ram_rdata;
  logic               par_bad;

  assign wr_ovf      = i_wrvld && ({1'b0, i_wrcnt} >= DEPTH_X);
  assign wr_acc      = i_wrvld && !wr_ovf && !i_vsync;
  // New row begins when address 0 follows a non-zero address.
  assign wr_toggle   = wr_acc && (wr_state_q == WR_ROW) && (i_wrcnt == '0) && last_nz_q;
  assign wr_bank_eff = wr_bank_q ^ wr_toggle;

  assign rd_go       = i_rdreq && !i_vsync;
  // The latch samples the registered writer bank, i.e. before any same-cycle toggle.
  assign rd_latch    = rd_go && !rd_active_q && (i_rdcnt == '0);
  assign rd_bank_eff = rd_latch ? wr_bank_q : rd_bank_q;
  assign rd_oob      = {1'b0, i_rdcnt} >= DEPTH_X;
  assign rd_haz      = rd_go && (rd_oob || ((rd_bank_eff == wr_bank_q) && (i_rdcnt > wr_hi_q)));

  // Writer FSM next state, row-progress tracking and overflow flag.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_bank_d  = wr_bank_q;
    wr_hi_d    = wr_hi_q;
    last_nz_d  = last_nz_q;
    wrovf_d    = wrovf_q | wr_ovf;
    if (i_vsync) begin
      wr_state_d = WR_IDLE;
      wr_bank_d  = 1'b0;
      wr_hi_d    = '0;
      last_nz_d  = 1'b0;
      wrovf_d    = 1'b0;
    end else if (wr_acc) begin
      last_nz_d = (i_wrcnt != '0);
      case (wr_state_q)
        WR_IDLE: begin
          wr_state_d = WR_ROW;
          wr_bank_d  = 1'b0;
          wr_hi_d    = i_wrcnt;
        end
        WR_ROW: begin
          wr_bank_d = wr_bank_eff;
          if (wr_toggle)              wr_hi_d = i_wrcnt;
          else if (i_wrcnt > wr_hi_q) wr_hi_d = i_wrcnt;
        end
        default: wr_state_d = WR_IDLE;
      endcase
    end
  end

  // Reader bank latch, activity tracking and sticky hazard flag.
  always_comb begin
    rd_active_d = rd_active_q;
    rd_bank_d   = rd_bank_q;
    rdhaz_d     = rdhaz_q | rd_haz;
    if (i_vsync) begin
      rd_active_d = 1'b0;
      rd_bank_d   = 1'b0;
      rdhaz_d     = 1'b0;
    end else if (rd_latch) begin
      rd_active_d = 1'b1;
      rd_bank_d   = wr_bank_q;
    end else if (!i_rdreq) begin
      rd_active_d = 1'b0;
    end
  end

`ifdef LINEBUF_PARITY_EN
  logic [THREAD-1:0] par_w;
  // Parity generation on write and lane-wise check on the RAM output.
  always_comb begin
    par_w   = '0;
    par_bad = 1'b0;
    for (int l = 0; l < THREAD; l++) begin
      par_w[l] = lane_parity(LANE_MAX'(i_wrdat[l*WIDTH_D +: WIDTH_D]));
      par_bad  = par_bad |
                 (lane_parity(LANE_MAX'(ram_rdata[l*WIDTH_D +: WIDTH_D])) ^ ram_rdata[W+l]);
    end
  end
  assign ram_wdata = {par_w, i_wrdat};
`else
  assign ram_wdata = i_wrdat;
  assign par_bad   = 1'b0;
`endif

  // Output stage: out-of-range reads return zero; data holds between reads.
  always_comb begin
    rddat_d  = rddat_q;
    parerr_d = 1'b0;
    if (vld_pipe_q[0]) begin
      rddat_d  = s1_oob_q ? '0 : ram_rdata[W-1:0];
      parerr_d = !s1_oob_q && par_bad;
    end
  end

  // All control and pipeline registers; async reset flushes in-flight reads.
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      wr_state_q  <= WR_IDLE;
      wr_bank_q   <= 1'b0;
      wr_hi_q     <= '0;
      last_nz_q   <= 1'b0;
      wrovf_q     <= 1'b0;
      rd_active_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      rdhaz_q     <= 1'b0;
      vld_pipe_q  <= '0;
      s1_oob_q    <= 1'b0;
      rddat_q     <= '0;
      parerr_q    <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      wr_bank_q   <= wr_bank_d;
      wr_hi_q     <= wr_hi_d;
      last_nz_q   <= last_nz_d;
      wrovf_q     <= wrovf_d;
      rd_active_q <= rd_active_d;
      rd_bank_q   <= rd_bank_d;
      rdhaz_q     <= rdhaz_d;
      vld_pipe_q  <= {vld_pipe_q[RD_LAT-2:0], rd_go};
      s1_oob_q    <= rd_go && rd_oob;
      rddat_q     <= rddat_d;
      parerr_q    <= parerr_d;
    end
  end

  sdp_ram #(
    .WIDTH (RAM_W),
    .DEPTH (2*DEPTH)
  ) u_ram (
    .clk_i   (i_sclk),
    .we_i    (wr_acc),
    .waddr_i ({wr_bank_eff, i_wrcnt[LA-1:0]}),
    .wdata_i (ram_wdata),
    .re_i    (rd_go),
    .raddr_i ({rd_bank_eff, i_rdcnt[LA-1:0]}),
    .rdata_o (ram_rdata)
  );

  assign o_rddat  = rddat_q;
  assign o_rdvld  = vld_pipe_q[RD_LAT-1];
  assign o_wrbank = wr_bank_q;
  assign o_rdbank = rd_bank_q;
  assign o_rdhaz  = rdhaz_q;
  assign o_wrovf  = wrovf_q;
  assign o_parerr = parerr_q;

endmodule

// File: tb/tb_linebuf_pingpong_resp.sv
// Directed bench for linebuf_pingpong_resp. DEPTH is set below 2**WIDTH_A so
// that overflowing write addresses and out-of-range reads can be presented.
module tb_linebuf_pingpong_resp;

  localparam int WIDTH_D = 27;
  localparam int THREAD  = 2;
  localparam int WIDTH_A = 10;
  localparam int DEPTH   = 512;
  localparam int W       = WIDTH_D * THREAD;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               vsync = 1'b0;
  logic               wrvld = 1'b0;
  logic [W-1:0]       wrdat = '0;
  logic [WIDTH_A-1:0] wrcnt = '0;
  logic               rdreq = 1'b0;
  logic [WIDTH_A-1:0] rdcnt = '0;
  logic [W-1:0]       o_rddat;
  logic               o_rdvld, o_wrbank, o_rdbank, o_rdhaz, o_wrovf, o_parerr;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int vld_cnt  = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   req_pipe;

  linebuf_pingpong_resp #(
    .WIDTH_D (WIDTH_D), .THREAD (THREAD), .WIDTH_A (WIDTH_A), .DEPTH (DEPTH)
  ) u_dut (
    .i_sclk (clk), .i_rst (rst), .i_vsync (vsync),
    .i_wrvld (wrvld), .i_wrdat (wrdat), .i_wrcnt (wrcnt),
    .i_rdreq (rdreq), .i_rdcnt (rdcnt),
    .o_rddat (o_rddat), .o_rdvld (o_rdvld), .o_wrbank (o_wrbank),
    .o_rdbank (o_rdbank), .o_rdhaz (o_rdhaz), .o_wrovf (o_wrovf),
    .o_parerr (o_parerr)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver tasks: inputs change 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic wv, input logic [WIDTH_A-1:0] wa, input logic [W-1:0] wd,
                     input logic rv, input logic [WIDTH_A-1:0] ra, input logic [W-1:0] rexp);
    wrvld = wv; wrcnt = wa; wrdat = wd;
    rdreq = rv; rdcnt = ra;
    if (rv) exp_q.push_back(rexp);
    tick();
    wrvld = 1'b0; rdreq = 1'b0;
  endtask

  task automatic wr(input logic [WIDTH_A-1:0] a, input logic [W-1:0] d);
    cyc(1'b1, a, d, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [WIDTH_A-1:0] a, input logic [W-1:0] e);
    cyc(1'b0, '0, '0, 1'b1, a, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
  endtask

  // Reference timing: a valid read request shows up as o_rdvld two edges later.
  always @(posedge clk or posedge rst) begin
    if (rst) req_pipe <= '0;
    else     req_pipe <= {req_pipe[0], rdreq & ~vsync};
  end

  // Scoreboard: checks valid timing, read data order and parity on every cycle.
  always @(negedge clk) begin
    logic [W-1:0] e;
    check_eq("rdvld", {63'd0, o_rdvld}, {63'd0, req_pipe[1]});
    if (o_rdvld) begin
      vld_cnt++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check_eq("rddat", 64'(o_rddat), 64'(e));
      check_eq("parerr", {63'd0, o_parerr}, 64'd0);
    end
  end

  initial begin
    // Reset state
    idle(3);
    check_eq("rst_rddat", 64'(o_rddat), 64'd0);
    check_eq("rst_wrbank", {63'd0, o_wrbank}, 64'd0);
    check_eq("rst_rdbank", {63'd0, o_rdbank}, 64'd0);
    check_eq("rst_rdhaz", {63'd0, o_rdhaz}, 64'd0);
    check_eq("rst_wrovf", {63'd0, o_wrovf}, 64'd0);
    check_eq("rst_parerr", {63'd0, o_parerr}, 64'd0);
    rst = 1'b0;
    tick();

    // Row 0: write 0..55 with data=addr, read back-to-back
    for (int a = 0; a < 56; a++) wr(WIDTH_A'(a), W'(a));
    check_eq("row0_wrbank", {63'd0, o_wrbank}, 64'd0);
    vld_cnt = 0;
    for (int a = 0; a < 56; a++) rd(WIDTH_A'(a), W'(a));
    idle(4);
    check_eq("row0_vld_cnt", 64'(vld_cnt), 64'd56);
    check_eq("row0_rdhaz", {63'd0, o_rdhaz}, 64'd0);
    check_eq("row0_rdbank", {63'd0, o_rdbank}, 64'd0);

    // Toggle to bank 1 in the same cycle the reader latches: reader keeps bank 0
    cyc(1'b1, '0, W'('hAA), 1'b1, '0, W'(0));
    check_eq("tog_wrbank", {63'd0, o_wrbank}, 64'd1);
    check_eq("tog_rdbank", {63'd0, o_rdbank}, 64'd0);
    for (int a = 1; a < 6; a++) rd(WIDTH_A'(a), W'(a));
    check_eq("tog_rdbank_frozen", {63'd0, o_rdbank}, 64'd0);
    idle(4);
    check_eq("tog_rdhaz", {63'd0, o_rdhaz}, 64'd0);
    // New read row follows the writer into bank 1
    rd('0, W'('hAA));
    check_eq("b1_rdbank", {63'd0, o_rdbank}, 64'd1);
    idle(4);
    check_eq("b1_rdhaz", {63'd0, o_rdhaz}, 64'd0);

    // Frame start clears control state; read data holds
    pulse_vsync();
    check_eq("vs_wrbank", {63'd0, o_wrbank}, 64'd0);
    check_eq("vs_rdbank", {63'd0, o_rdbank}, 64'd0);
    check_eq("vs_rddat_hold", 64'(o_rddat), 64'hAA);

    // Hazard: wr_hi=5, read addr 10 in the writer's bank
    for (int a = 0; a < 6; a++) wr(WIDTH_A'(a), W'('h100 + a));
    rd('0, W'('h100));
    check_eq("haz_pre", {63'd0, o_rdhaz}, 64'd0);
    rd(WIDTH_A'(10), W'(10));
    check_eq("haz_set", {63'd0, o_rdhaz}, 64'd1);
    idle(4);
    check_eq("haz_sticky", {63'd0, o_rdhaz}, 64'd1);
    pulse_vsync();
    check_eq("haz_clr", {63'd0, o_rdhaz}, 64'd0);

    // Overflow: address DEPTH is dropped, aliased word 0 is untouched
    wr(WIDTH_A'(DEPTH), W'('h3FF));
    check_eq("ovf_set", {63'd0, o_wrovf}, 64'd1);
    check_eq("ovf_wrbank", {63'd0, o_wrbank}, 64'd0);
    wr(WIDTH_A'(DEPTH + 88), W'('h3FE));
    rd('0, W'('h100));
    idle(4);
    check_eq("ovf_sticky", {63'd0, o_wrovf}, 64'd1);
    check_eq("ovf_rdhaz", {63'd0, o_rdhaz}, 64'd0);

    // Same-cycle read/write of address 3 is read-first
    pulse_vsync();
    check_eq("vs_wrovf", {63'd0, o_wrovf}, 64'd0);
    for (int a = 0; a < 3; a++) wr(WIDTH_A'(a), W'('h30 + a));
    wr(WIDTH_A'(3), W'('h22));
    rd('0, W'('h30));
    cyc(1'b1, WIDTH_A'(3), W'('h11), 1'b1, WIDTH_A'(3), W'('h22));
    rd(WIDTH_A'(3), W'('h11));
    idle(4);
    check_eq("rf_rdhaz", {63'd0, o_rdhaz}, 64'd0);
    check_eq("rf_wrbank", {63'd0, o_wrbank}, 64'd0);

    // Out-of-range read returns zero and flags a hazard
    rd(WIDTH_A'(DEPTH + 88), '0);
    check_eq("oob_rdhaz", {63'd0, o_rdhaz}, 64'd1);
    idle(4);
    check_eq("oob_rddat", 64'(o_rddat), 64'd0);

    // Reset mid-read flushes the pipeline
    rd('0, W'('h30));
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    exp_q.delete();
    idle(3);
    check_eq("flush_rdvld", {63'd0, o_rdvld}, 64'd0);
    check_eq("flush_rdhaz", {63'd0, o_rdhaz}, 64'd0);
    check_eq("flush_wrovf", {63'd0, o_wrovf}, 64'd0);

    // Final report
    idle(2);
    check_eq("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
